// File: rtl/mvf_reader.sv
// Raster-scan reader for the motion-vector field RAMs (LFMVram x/y and Pram) with a small output FIFO.
// Reads are throttled so that buffered entries plus in-flight reads never exceed the FIFO depth.
module mvf_reader #(
   parameter int ADDR_W     = 16,
   parameter int MV_W       = 9,
   parameter int P_W        = 6,
   parameter int RAM_LAT    = 1,
   parameter int FIFO_DEPTH = 4
) (
   input  logic              CLK,
   input  logic              reset,
   input  logic              start,
   input  logic [7:0]        height,
   input  logic [7:0]        width,
   output logic [ADDR_W-1:0] rd_index,
   output logic              rd_en,
   input  logic [MV_W-1:0]   doutax,
   input  logic [MV_W-1:0]   doutay,
   input  logic [P_W-1:0]    pdi,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [MV_W-1:0]   out_mvx,
   output logic [MV_W-1:0]   out_mvy,
   output logic [P_W-1:0]    out_p,
   output logic [7:0]        out_col,
   output logic [7:0]        out_row,
   output logic              out_last,
   output logic              busy,
   output logic              done
);
   // state | meaning
   // IDLE  | waiting for start
   // RUN   | issuing reads in raster order
   // DRAIN | all reads issued, emptying read pipeline and FIFO
   // FIN   | one-cycle done pulse
   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_RUN   = 2'd1;
   localparam logic [1:0] S_DRAIN = 2'd2;
   localparam logic [1:0] S_FIN   = 2'd3;

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
   localparam int IFL_W = $clog2(RAM_LAT + 1);
   localparam int ENT_W = 2 * MV_W + P_W + 17;

   logic [1:0]        state_q, state_d;
   logic [7:0]        h_q, w_q, col_q, row_q;
   logic [ADDR_W-1:0] idx_q;
   logic [RAM_LAT-1:0] pv_q;
   logic [RAM_LAT-1:0] plast_q;
   logic [7:0]        pcol_q [RAM_LAT];
   logic [7:0]        prow_q [RAM_LAT];
   logic [IFL_W-1:0]  infl_q;
   logic [ENT_W-1:0]  mem_q [FIFO_DEPTH];
   logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
   logic [CNT_W-1:0]  cnt_q;

   logic             issue, issue_last, col_end, row_end;
   logic             push, pop, accept_start, head_last;
   logic [ENT_W-1:0] head;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
   endfunction

   // Gating looks only at registered occupancy, so out_ready never reaches rd_en.
   assign issue        = (state_q == S_RUN) && ((int'(cnt_q) + int'(infl_q)) < FIFO_DEPTH);
   assign col_end      = (col_q == w_q - 8'd1);
   assign row_end      = (row_q == h_q - 8'd1);
   assign issue_last   = col_end && row_end;
   assign accept_start = (state_q == S_IDLE) && start;

   assign push      = pv_q[RAM_LAT-1];
   assign out_valid = (cnt_q != '0);
   assign pop       = out_valid && out_ready;
   assign head      = mem_q[rd_ptr_q];
   assign head_last = head[16];

   assign rd_en    = issue;
   assign rd_index = idx_q;
   assign busy     = (state_q == S_RUN) || (state_q == S_DRAIN);
   assign done     = (state_q == S_FIN);

   assign out_col  = out_valid ? head[7:0]                     : '0;
   assign out_row  = out_valid ? head[15:8]                    : '0;
   assign out_last = out_valid ? head[16]                      : 1'b0;
   assign out_p    = out_valid ? head[17 +: P_W]               : '0;
   assign out_mvy  = out_valid ? head[17 + P_W +: MV_W]        : '0;
   assign out_mvx  = out_valid ? head[17 + P_W + MV_W +: MV_W] : '0;

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: begin
            if (start) state_d = (height == 8'd0 || width == 8'd0) ? S_FIN : S_RUN;
         end
         S_RUN:   if (issue && issue_last) state_d = S_DRAIN;
         S_DRAIN: if (pop && head_last) state_d = S_FIN;
         S_FIN:   state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (reset) begin
         state_q  <= S_IDLE;
         h_q      <= '0;
         w_q      <= '0;
         col_q    <= '0;
         row_q    <= '0;
         idx_q    <= '0;
         pv_q     <= '0;
         plast_q  <= '0;
         infl_q   <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
         for (int k = 0; k < RAM_LAT; k++) begin
            pcol_q[k] <= '0;
            prow_q[k] <= '0;
         end
      end else begin
         state_q <= state_d;

         if (accept_start) begin
            h_q   <= height;
            w_q   <= width;
            col_q <= '0;
            row_q <= '0;
            idx_q <= '0;
         end else if (issue) begin
            // raster order means row*w+col simply counts up by one per read
            idx_q <= idx_q + ADDR_W'(1);
            if (col_end) begin
               col_q <= '0;
               row_q <= row_q + 8'd1;
            end else begin
               col_q <= col_q + 8'd1;
            end
         end

         pv_q[0]    <= issue;
         plast_q[0] <= issue_last;
         pcol_q[0]  <= col_q;
         prow_q[0]  <= row_q;
         for (int k = 1; k < RAM_LAT; k++) begin
            pv_q[k]    <= pv_q[k-1];
            plast_q[k] <= plast_q[k-1];
            pcol_q[k]  <= pcol_q[k-1];
            prow_q[k]  <= prow_q[k-1];
         end

         case ({issue, push})
            2'b10:   infl_q <= infl_q + IFL_W'(1);
            2'b01:   infl_q <= infl_q - IFL_W'(1);
            default: infl_q <= infl_q;
         endcase

         if (push) begin
            mem_q[wr_ptr_q] <= {doutax, doutay, pdi, plast_q[RAM_LAT-1],
                                prow_q[RAM_LAT-1], pcol_q[RAM_LAT-1]};
            wr_ptr_q        <= ptr_inc(wr_ptr_q);
         end
         if (pop) rd_ptr_q <= ptr_inc(rd_ptr_q);

         case ({push, pop})
            2'b10:   cnt_q <= cnt_q + CNT_W'(1);
            2'b01:   cnt_q <= cnt_q - CNT_W'(1);
            default: cnt_q <= cnt_q;
         endcase
      end
   end

   a_no_overflow: assert property (@(posedge CLK) disable iff (reset)
      !(push && cnt_q == CNT_W'(FIFO_DEPTH)));

endmodule

// File: tb/tb_mvf_reader.sv
// Randomized bench for mvf_reader: a RAM model plus a raster-order expected-beat queue
// built directly from height/width, checked beat by beat with stall-hold checks.
module tb_mvf_reader;
   localparam int DEPTH = 4;

   logic        CLK = 1'b0;
   logic        reset, start, out_ready;
   logic [7:0]  height, width;
   logic [15:0] rd_index;
   logic        rd_en;
   logic [8:0]  doutax, doutay;
   logic [5:0]  pdi;
   logic        out_valid;
   logic [8:0]  out_mvx, out_mvy;
   logic [5:0]  out_p;
   logic [7:0]  out_col, out_row;
   logic        out_last, busy, done;

   int n_tests = 0;
   int n_fail  = 0;
   int r_first_rd, r_first_val, r_last_beat, r_done, r_stall_rd, r_last_rd;

   mvf_reader dut (
      .CLK(CLK), .reset(reset), .start(start), .height(height), .width(width),
      .rd_index(rd_index), .rd_en(rd_en), .doutax(doutax), .doutay(doutay), .pdi(pdi),
      .out_valid(out_valid), .out_ready(out_ready), .out_mvx(out_mvx), .out_mvy(out_mvy),
      .out_p(out_p), .out_col(out_col), .out_row(out_row), .out_last(out_last),
      .busy(busy), .done(done)
   );

   always #5 CLK = ~CLK;

   // one-cycle-latency RAM; garbage on cycles without a read
   always @(posedge CLK) begin
      if (rd_en) begin
         doutax <= rd_index[8:0];
         doutay <= ~rd_index[8:0];
         pdi    <= rd_index[5:0];
      end else begin
         doutax <= 9'($urandom);
         doutay <= 9'($urandom);
         pdi    <= 6'($urandom);
      end
   end

   task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [40:0] exp_beat(input int h, input int w, input int r, input int c);
      logic [15:0] ix;
      logic [8:0]  lo;
      ix = 16'(r * w + c);
      lo = ix[8:0];
      return {lo, ~lo, lo[5:0], 8'(c), 8'(r), (r == h - 1) && (c == w - 1)};
   endfunction

   task automatic run_scan(input string nm, input int h, input int w, input int rdy_pct,
                           input int stall_cyc, input int restart_cyc, input int reset_beat);
      logic [40:0] expq[$];
      logic [40:0] beat, prev_beat;
      logic        hold;
      int cyc, beats, done_cnt, rd_cnt, exp_rd, limit, quiet;
      for (int r = 0; r < h; r++)
         for (int c = 0; c < w; c++) expq.push_back(exp_beat(h, w, r, c));
      r_first_rd = -1; r_first_val = -1; r_last_beat = -1; r_done = -1;
      r_stall_rd = 0; r_last_rd = -1;
      cyc = 0; beats = 0; done_cnt = 0; rd_cnt = 0; exp_rd = 0; hold = 1'b0;
      prev_beat = '0;
      limit = 4 * h * w + 60 + stall_cyc;

      @(posedge CLK); #1;
      height = 8'(h); width = 8'(w); start = 1'b1; out_ready = 1'b0;
      while (1) begin
         @(posedge CLK); #1;
         cyc++;
         start = (cyc == restart_cyc);
         if (start) begin
            height = 8'(h + 1);
            width  = 8'(w + 2);
         end
         beat = {out_mvx, out_mvy, out_p, out_col, out_row, out_last};
         if (hold) check_eq({nm, "_hold"}, {out_valid, beat}, {1'b1, prev_beat});
         if (rd_en) begin
            check_eq({nm, "_rd_index"}, rd_index, exp_rd);
            exp_rd++;
            rd_cnt++;
            r_last_rd = rd_index;
            if (r_first_rd < 0) r_first_rd = cyc;
            if (cyc <= stall_cyc) r_stall_rd++;
         end
         if (done) begin
            done_cnt++;
            r_done = cyc;
         end
         out_ready = (cyc > stall_cyc) && (int'($urandom_range(99)) < rdy_pct);
         hold = out_valid && !out_ready;
         prev_beat = beat;
         if (out_valid) begin
            if (r_first_val < 0) r_first_val = cyc;
            if (out_ready) begin
               if (expq.size() == 0) check_eq({nm, "_extra_beat"}, 1, 0);
               else check_eq({nm, "_beat"}, beat, expq.pop_front());
               beats++;
               r_last_beat = cyc;
               if (beats == reset_beat) begin
                  reset = 1'b1;
                  @(posedge CLK); #1;
                  check_eq({nm, "_rst_busy"}, busy, 0);
                  check_eq({nm, "_rst_valid"}, out_valid, 0);
                  check_eq({nm, "_rst_done"}, done, 0);
                  reset = 1'b0;
                  out_ready = 1'b0;
                  quiet = 0;
                  repeat (6) begin
                     @(posedge CLK); #1;
                     quiet += int'(done) + int'(out_valid) + int'(busy) + int'(rd_en);
                  end
                  check_eq({nm, "_rst_quiet"}, quiet, 0);
                  return;
               end
            end
         end
         if (done_cnt > 0 && cyc >= r_done + 2) break;
         if (cyc > limit) begin
            check_eq({nm, "_timeout"}, cyc, limit);
            break;
         end
      end
      out_ready = 1'b0;
      check_eq({nm, "_nbeats"}, beats, h * w);
      check_eq({nm, "_leftover"}, expq.size(), 0);
      check_eq({nm, "_rd_cnt"}, rd_cnt, h * w);
      check_eq({nm, "_done_cnt"}, done_cnt, 1);
      if (h * w > 0) check_eq({nm, "_done_cyc"}, r_done, r_last_beat + 1);
   endtask

   initial begin
      reset = 1'b1; start = 1'b0; out_ready = 1'b0; height = '0; width = '0;
      repeat (3) @(posedge CLK);
      #1;
      check_eq("rst_busy", busy, 0);
      check_eq("rst_done", done, 0);
      check_eq("rst_rd_en", rd_en, 0);
      check_eq("rst_valid", out_valid, 0);
      check_eq("rst_index", rd_index, 0);
      check_eq("rst_data", {out_mvx, out_mvy, out_p, out_col, out_row, out_last}, 0);
      reset = 1'b0;

      run_scan("basic", 2, 3, 100, 0, -1, -1);
      check_eq("basic_first_rd", r_first_rd, 1);
      check_eq("basic_first_val", r_first_val, 3);
      check_eq("basic_last_beat", r_last_beat, 8);
      check_eq("basic_done", r_done, 9);

      run_scan("rand50", 5, 7, 50, 0, -1, -1);

      run_scan("stall", 3, 4, 70, 20, -1, -1);
      check_eq("stall_issues", r_stall_rd, DEPTH);

      run_scan("w0", 3, 0, 100, 0, -1, -1);
      check_eq("w0_done_window", (r_done == 1 || r_done == 2), 1);
      check_eq("w0_no_valid", r_first_val, -1);
      run_scan("h0", 0, 5, 100, 0, -1, -1);
      check_eq("h0_done_window", (r_done == 1 || r_done == 2), 1);
      check_eq("h0_no_valid", r_first_val, -1);

      run_scan("restart", 3, 3, 60, 0, 4, -1);

      for (int i = 0; i < 3; i++)
         run_scan("rand", int'($urandom_range(6, 1)), int'($urandom_range(6, 1)),
                  int'($urandom_range(90, 20)), 0, -1, -1);

      run_scan("midreset", 4, 8, 100, 0, -1, 10);

      run_scan("max", 255, 255, 100, 0, -1, -1);
      check_eq("max_last_index", r_last_rd, 65024);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
